// File: rtl/tfe_pkg.sv
//------------------------------------------------------------------------------
// Package : tfe_pkg
// Purpose : Shared constants for the 2048 board transmit path. It holds the
//           ASCII control and glyph bytes, the frame geometry and the
//           board_tx_sequencer FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package tfe_pkg;

  // ASCII bytes used in the frame
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] ESC    = 8'h1B;
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] LBRACK = 8'h5B;
  localparam logic [7:0] CHAR_H = 8'h48;

  // Frame geometry: 4 rows of 4 cells (5 chars each) plus CR LF
  localparam int CELL_CH = 5;
  localparam int ROW_CH  = 22;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage : tfe_pkg

`default_nettype wire

// File: rtl/board_tx_sequencer_rom.sv
//------------------------------------------------------------------------------
// Module  : tile_ascii_rom
// Purpose : Combinational glyph table giving the 4-character, right-justified
//           text of one tile.
// Ports   : exp_i  [3:0] tile exponent (0 = empty, e -> 2^e)
//           pos_i  [1:0] character position in the digit field (0 = leftmost)
//           char_o [7:0] ASCII character at that position
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tile_ascii_rom
  import tfe_pkg::*;
#(
  parameter logic [7:0] EMPTY_CHAR = 8'h2E,
  parameter logic [7:0] OVF_CHAR   = 8'h23
) (
  input  logic [3:0] exp_i,
  input  logic [1:0] pos_i,
  output logic [7:0] char_o
);

  logic [31:0] glyph;

  always_comb begin
    glyph = {4{OVF_CHAR}};              // exponents 12..15 overflow the field
    case (exp_i)
      4'd0:    glyph = {SPACE, SPACE, SPACE, EMPTY_CHAR};
      4'd1:    glyph = "   2";
      4'd2:    glyph = "   4";
      4'd3:    glyph = "   8";
      4'd4:    glyph = "  16";
      4'd5:    glyph = "  32";
      4'd6:    glyph = "  64";
      4'd7:    glyph = " 128";
      4'd8:    glyph = " 256";
      4'd9:    glyph = " 512";
      4'd10:   glyph = "1024";
      4'd11:   glyph = "2048";
      default: glyph = {4{OVF_CHAR}};
    endcase
  end

  always_comb begin
    char_o = glyph[31:24];
    case (pos_i)
      2'd0: char_o = glyph[31:24];
      2'd1: char_o = glyph[23:16];
      2'd2: char_o = glyph[15:8];
      2'd3: char_o = glyph[7:0];
      default: char_o = glyph[31:24];
    endcase
  end

endmodule : tile_ascii_rom

`default_nettype wire

// File: rtl/board_tx_sequencer.sv
//------------------------------------------------------------------------------
// Module  : board_tx_sequencer
// Purpose : Takes a snapshot of the 4x4 2048 board and streams it as an ASCII
//           frame, one byte per UART handshake. The frame is an optional
//           ESC [ H prefix followed by 4 rows of 4 five-character cells + CR LF.
// Ports   : clk              system clock
//           rst              asynchronous, active-low reset
//           i_start          one-cycle request to send the current board
//           i_board   [63:0] 16 x 4-bit exponents, tile r*4+c at [4*(r*4+c)+:4]
//           i_tx_busy        UART transmitter busy
//           o_tx_data [7:0]  byte to transmit
//           o_tx_valid       one-cycle strobe qualifying o_tx_data
//           o_busy           frame in progress
//           o_done           one-cycle pulse after the last byte is accepted
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module board_tx_sequencer
  import tfe_pkg::*;
#(
  parameter int         SEND_HOME  = 1,
  parameter logic [7:0] EMPTY_CHAR = 8'h2E,
  parameter logic [7:0] OVF_CHAR   = 8'h23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [63:0] i_board,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_busy,
  output logic        o_done
);

  localparam int         PRE_LEN  = (SEND_HOME != 0) ? 3 : 0;
  localparam logic [6:0] PRE_LEN7 = 7'(PRE_LEN);
  localparam logic [6:0] LAST     = 7'(ROWS * ROW_CH + PRE_LEN - 1);

  state_e      state_q, state_d;
  logic [63:0] snap_q, snap_d;
  logic [6:0]  idx_q, idx_d;
  logic [1:0]  row_q, row_d;
  logic [2:0]  cell_q, cell_d;          // 0..3 = tile cells, 4 = CR/LF tail
  logic [2:0]  pos_q, pos_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // ---------------------------------------------------------------------------
  // Byte generation from (snapshot, idx) with geometry counters
  // ---------------------------------------------------------------------------
  logic       in_prefix;
  logic [3:0] tile_exp;
  logic [1:0] rom_pos;
  logic [7:0] rom_char;
  logic [7:0] cur_byte;

  assign in_prefix = (idx_q < PRE_LEN7);
  assign tile_exp  = snap_q[{row_q, cell_q[1:0], 2'b00} +: 4];
  // Digit-field positions 1..4 map to ROM positions 0..3; pos 4 wraps to 0
  // in two bits, so subtracting one lands on 3.
  assign rom_pos   = pos_q[1:0] - 2'd1;

  tile_ascii_rom #(
    .EMPTY_CHAR (EMPTY_CHAR),
    .OVF_CHAR   (OVF_CHAR)
  ) u_rom (
    .exp_i  (tile_exp),
    .pos_i  (rom_pos),
    .char_o (rom_char)
  );

  always_comb begin
    cur_byte = SPACE;
    if (in_prefix) begin
      case (idx_q[1:0])
        2'd0:    cur_byte = ESC;
        2'd1:    cur_byte = LBRACK;
        default: cur_byte = CHAR_H;
      endcase
    end else if (cell_q == 3'(COLS)) begin
      cur_byte = (pos_q == 3'd0) ? CR : LF;
    end else if (pos_q == 3'd0) begin
      cur_byte = SPACE;
    end else begin
      cur_byte = rom_char;
    end
  end

  // Counter values for the following byte; the prefix bytes do not move them.
  logic [1:0] step_row;
  logic [2:0] step_cell;
  logic [2:0] step_pos;

  always_comb begin
    step_row  = row_q;
    step_cell = cell_q;
    step_pos  = pos_q;
    if (!in_prefix) begin
      if (cell_q == 3'(COLS)) begin
        if (pos_q == 3'd1) begin
          step_pos  = 3'd0;
          step_cell = 3'd0;
          step_row  = row_q + 2'd1;
        end else begin
          step_pos  = pos_q + 3'd1;
        end
      end else if (pos_q == 3'(CELL_CH - 1)) begin
        step_pos  = 3'd0;
        step_cell = cell_q + 3'd1;
      end else begin
        step_pos  = pos_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    row_d      = row_q;
    cell_d     = cell_q;
    pos_d      = pos_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (i_start) begin
          snap_d  = i_board;
          idx_d   = 7'd0;
          row_d   = 2'd0;
          cell_d  = 3'd0;
          pos_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!i_tx_busy) begin
          tx_data_d  = cur_byte;
          tx_valid_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // The strobe is issued exactly once; a late busy just waits here.
        if (i_tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          if (idx_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 7'd1;
            row_d   = step_row;
            cell_d  = step_cell;
            pos_d   = step_pos;
            state_d = ISSUE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      snap_q     <= 64'd0;
      idx_q      <= 7'd0;
      row_q      <= 2'd0;
      cell_q     <= 3'd0;
      pos_q      <= 3'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      cell_q     <= cell_d;
      pos_q      <= pos_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule : board_tx_sequencer

`default_nettype wire
